// File: rtl/detector_casamento_if.sv
// Bundles the comparator-side inputs and the event/status outputs of the match detector.
// The "slave" modport is the detector itself; "master" is whoever drives and polls it.
interface detector_casamento_if #(
  parameter int CNT_WIDTH = 8
) ();

  logic                 en;
  logic                 match_in;
  logic                 clear;
  logic                 event_pulse;
  logic                 event_flag;
  logic [CNT_WIDTH-1:0] event_count;
  logic                 overflow;
  logic                 busy;

  modport master (
    output en, match_in, clear,
    input  event_pulse, event_flag, event_count, overflow, busy
  );

  modport slave (
    input  en, match_in, clear,
    output event_pulse, event_flag, event_count, overflow, busy
  );

endinterface

// File: rtl/detector_casamento.sv
// Qualifies a comparator match held for HOLD consecutive enabled cycles, emits one
// event per match episode and keeps a saturating event counter with sticky flags.
module detector_casamento #(
  parameter int HOLD      = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  detector_casamento_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [7:0]           HOLD_LAST = 8'(HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_e               state_q, state_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic                 fire;
  logic                 pulse_q;
  logic                 flag_q, flag_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    fire       = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.match_in) begin
            if (HOLD == 1) begin
              fire    = 1'b1;
              state_d = LOCKED;
            end else begin
              state_d    = QUALIFY;
              hold_cnt_d = 8'd1;
            end
          end
        end
        QUALIFY: begin
          if (!bus.match_in) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            fire       = 1'b1;
            state_d    = LOCKED;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
        LOCKED: begin
          if (!bus.match_in) state_d = IDLE;
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Clear is applied first so an event on the same edge counts on top of the cleared value.
  always_comb begin
    count_d = bus.clear ? '0 : count_q;
    flag_d  = flag_q & ~bus.clear;
    ovf_d   = ovf_q & ~bus.clear;
    if (fire) begin
      flag_d = 1'b1;
      if (count_d == CNT_MAX) ovf_d   = 1'b1;
      else                    count_d = count_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      pulse_q    <= 1'b0;
      flag_q     <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pulse_q    <= fire;
      flag_q     <= flag_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.event_pulse = pulse_q;
  assign bus.event_flag  = flag_q;
  assign bus.event_count = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_detector_casamento.sv
// Directed bench for detector_casamento: main instance (HOLD=3, 8-bit count), a 2-bit
// count instance for saturation and a HOLD=1 instance, all fed the same inputs.
module tb_detector_casamento;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic match = 1'b0;
  logic clear = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  detector_casamento_if #(.CNT_WIDTH(8)) a_if ();
  detector_casamento_if #(.CNT_WIDTH(2)) s_if ();
  detector_casamento_if #(.CNT_WIDTH(8)) h_if ();

  assign a_if.en = en;  assign a_if.match_in = match;  assign a_if.clear = clear;
  assign s_if.en = en;  assign s_if.match_in = match;  assign s_if.clear = clear;
  assign h_if.en = en;  assign h_if.match_in = match;  assign h_if.clear = clear;

  detector_casamento #(.HOLD(3), .CNT_WIDTH(8)) dut     (.clk(clk), .rst(rst), .bus(a_if.slave));
  detector_casamento #(.HOLD(3), .CNT_WIDTH(2)) dut_sat (.clk(clk), .rst(rst), .bus(s_if.slave));
  detector_casamento #(.HOLD(1), .CNT_WIDTH(8)) dut_h1  (.clk(clk), .rst(rst), .bus(h_if.slave));

  // Qualification pattern with expected pulse/busy after each edge (HOLD=3).
  localparam bit Q_M[9] = '{1, 1, 0, 1, 1, 1, 1, 1, 0};
  localparam bit Q_P[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  localparam bit Q_B[9] = '{1, 1, 0, 1, 1, 1, 1, 1, 0};
  // Enable gating with match held high.
  localparam bit G_E[5] = '{1, 0, 0, 1, 1};
  localparam bit G_P[5] = '{0, 0, 0, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; match = 1'b0; clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive one cycle, then check main-instance pulse and busy.
  task automatic step(input logic m, input logic e, input logic c,
                      input logic ep, input logic eb, input string tag);
    match = m; en = e; clear = c;
    tick();
    check({tag, ".pulse"}, 32'(a_if.event_pulse), 32'(ep));
    check({tag, ".busy"},  32'(a_if.busy),        32'(eb));
  endtask

  task automatic check_main(input string tag, input int cnt, input logic flg, input logic ovf);
    check({tag, ".count"}, 32'(a_if.event_count), cnt);
    check({tag, ".flag"},  32'(a_if.event_flag),  32'(flg));
    check({tag, ".ovf"},   32'(a_if.overflow),    32'(ovf));
  endtask

  int pulses;

  initial begin
    // Reset held with match high: everything stays zero.
    rst = 1'b1; en = 1'b1; match = 1'b1; clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst.outs", 32'({a_if.event_pulse, a_if.event_flag, a_if.overflow, a_if.busy}), 32'd0);
      check("rst.count", 32'(a_if.event_count), 32'd0);
    end
    rst = 1'b0;
    step(1, 1, 0, 0, 1, "rst.e1");
    step(1, 1, 0, 0, 1, "rst.e2");
    step(1, 1, 0, 1, 1, "rst.e3");
    check_main("rst.after", 1, 1, 0);

    // Qualification with an abandoned episode.
    do_reset();
    for (int i = 0; i < 9; i++) step(Q_M[i], 1, 0, Q_P[i], Q_B[i], $sformatf("qual.%0d", i));
    check_main("qual.end", 1, 1, 0);

    // Enable gating: disabled cycles neither count nor break the run.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, G_E[i], 0, G_P[i], 1, $sformatf("gate.%0d", i));

    // Re-arm plus clear collision.
    do_reset();
    step(1, 1, 0, 0, 1, "rearm.a0");
    step(1, 1, 0, 0, 1, "rearm.a1");
    step(1, 1, 0, 1, 1, "rearm.a2");
    step(1, 1, 0, 0, 1, "rearm.a3");
    step(1, 1, 0, 0, 1, "rearm.a4");
    step(0, 1, 0, 0, 0, "rearm.a5");
    step(1, 1, 0, 0, 1, "rearm.b0");
    step(1, 1, 0, 0, 1, "rearm.b1");
    step(1, 1, 0, 1, 1, "rearm.b2");
    step(1, 1, 0, 0, 1, "rearm.b3");
    step(1, 1, 0, 0, 1, "rearm.b4");
    step(0, 1, 0, 0, 0, "rearm.b5");
    check_main("rearm.two", 2, 1, 0);
    step(1, 1, 0, 0, 1, "coll.0");
    step(1, 1, 0, 0, 1, "coll.1");
    step(1, 1, 1, 1, 1, "coll.2");
    check_main("coll.ev", 1, 1, 0);
    step(0, 1, 1, 0, 0, "clr.0");
    check_main("clr.alone", 0, 0, 0);

    // Continuous high: only one event.
    pulses = 0;
    match = 1'b1; en = 1'b1; clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_if.event_pulse === 1'b1) pulses++;
    end
    check("long.pulses", 32'(pulses), 32'd1);
    check_main("long.end", 1, 1, 0);

    // Clear honoured while disabled; state frozen (still busy).
    step(0, 0, 1, 0, 1, "clr_dis");
    check_main("clr_dis.st", 0, 0, 0);

    // Saturation on the 2-bit instance.
    do_reset();
    for (int ep = 0; ep < 4; ep++) begin
      step(1, 1, 0, 0, 1, $sformatf("sat%0d.0", ep));
      step(1, 1, 0, 0, 1, $sformatf("sat%0d.1", ep));
      match = 1'b1; tick();
      check($sformatf("sat%0d.pulse", ep), 32'(s_if.event_pulse), 32'd1);
      check($sformatf("sat%0d.count", ep), 32'(s_if.event_count), (ep < 3) ? ep + 1 : 3);
      check($sformatf("sat%0d.ovf", ep),   32'(s_if.overflow),    (ep == 3) ? 32'd1 : 32'd0);
      step(0, 1, 0, 0, 0, $sformatf("sat%0d.low", ep));
    end
    match = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    check("sat.clr", 32'({s_if.event_count, s_if.overflow, s_if.event_flag}), 32'd0);

    // HOLD=1: event on the very first matching edge.
    do_reset();
    match = 1'b1; tick();
    check("h1.pulse0", 32'({h_if.event_pulse, h_if.busy}), 32'b11);
    tick();
    check("h1.locked", 32'({h_if.event_pulse, h_if.busy}), 32'b01);
    match = 1'b0; tick();
    check("h1.idle",   32'({h_if.event_pulse, h_if.busy}), 32'b00);
    match = 1'b1; tick();
    check("h1.pulse1", 32'(h_if.event_pulse), 32'd1);
    check("h1.count",  32'(h_if.event_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/detector_casamento.md
Name: detector_casamento

Overview:
- Downstream consumer of the constant-comparator stage; takes its single-bit `result` on `match_in`.
- Qualifies a match only after it has held for HOLD consecutive enabled cycles, then emits one event per match episode.
- Keeps a saturating event counter and sticky flags for polling logic or a 7-segment/LED display stage.
- All outputs are registered.

Parameters:
- HOLD, 3, consecutive enabled cycles `match_in` must be 1 to qualify an event (legal range 1..255).
- CNT_WIDTH, 8, width of `event_count`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  sampling enable; 0 freezes all state.
- match_in  input  1  comparator result (level, synchronous to clk).
- clear  input  1  single-cycle request to clear `event_count`, `event_flag` and `overflow`.
- event_pulse  output  1  one-cycle strobe per qualified event.
- event_flag  output  1  sticky; set by an event, cleared by `clear`.
- event_count  output  CNT_WIDTH  number of events since reset/clear, saturating.
- overflow  output  1  sticky; set when an event occurs with `event_count` at max.
- busy  output  1  1 while the FSM is in QUALIFY or LOCKED.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (`rst`=1 at an edge): state=IDLE, hold_cnt=0, event_pulse=0, event_flag=0, event_count=0, overflow=0, busy=0. `rst` overrides `en` and `clear`. Reset mid-QUALIFY or mid-LOCKED discards progress; no event is emitted.
- Internal hold counter: hold_cnt, 8 bits.
- FSM, evaluated only at edges with en=1:
  - IDLE:
    - match_in=0 -> stay.
    - match_in=1 and HOLD=1 -> event, go to LOCKED.
    - match_in=1 and HOLD>1 -> QUALIFY, hold_cnt=1.
  - QUALIFY:
    - match_in=0 -> IDLE, hold_cnt=0 (the episode is abandoned).
    - match_in=1 and hold_cnt=HOLD-1 -> event, go to LOCKED, hold_cnt=0.
    - Otherwise hold_cnt += 1.
  - LOCKED:
    - match_in=1 -> stay (no re-trigger).
    - match_in=0 -> IDLE (re-armed).
- Event at an edge:
  - event_pulse=1 for exactly the following cycle.
  - event_flag=1.
  - event_count += 1 if below 2^CNT_WIDTH-1; otherwise the count holds and overflow=1.
- event_pulse returns to 0 at the next edge unconditionally.
- Latency: with match_in=1 sampled at edges k..k+HOLD-1, event_pulse is high from edge k+HOLD-1 to edge k+HOLD.
- en=0 at an edge: state, hold_cnt, event_count and flags hold; event_pulse=0; match_in is ignored, so the consecutive requirement spans only enabled cycles. `clear` is still honoured when en=0.
- clear=1 at an edge with no event: event_count=0, event_flag=0, overflow=0. FSM state is unaffected.
- clear and an event at the same edge: the event wins after the clear. Result: event_count=1, event_flag=1, overflow=0, event_pulse=1.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: drive rst=1 for 2 cycles with match_in=1, en=1 -> all outputs 0 during reset and on the first cycle after release; first event_pulse appears 3 edges after release (HOLD=3).
- Qualification: HOLD=3, en=1, match_in pattern 1,1,0,1,1,1,1,1,0 -> exactly one event_pulse, on the cycle after the 6th edge; event_count=1; busy falls after the final 0.
- Enable gating: HOLD=3, match_in held at 1, en pattern 1,0,0,1,1 -> event_pulse only after the 5th edge; no pulse while en=0.
- Re-arm: two separate episodes of match_in high for 5 cycles, separated by one low cycle -> event_count=2, two pulses; a continuous 20-cycle high gives only 1.
- Saturation: CNT_WIDTH=2, 4 episodes -> event_count=3 after the 3rd; the 4th pulses, sets overflow=1, and event_count stays 3.
- Clear collision: event_count=2, assert clear on the same edge as an event -> event_count=1, event_flag=1, overflow=0; clear alone on a later edge -> event_count=0, event_flag=0.
